// File: rtl/SB_codex_pkg.sv
// Sideband codec types shared by the LTSM state blocks: message struct,
// field enums, header bit positions and the message-number decoder.
package SB_codex_pkg;

  localparam int unsigned OPC_LSB     = 0;
  localparam int unsigned OPC_MSB     = 4;
  localparam int unsigned MSGCODE_LSB = 14;
  localparam int unsigned MSGCODE_MSB = 21;
  localparam int unsigned SRCID_LSB   = 29;
  localparam int unsigned SRCID_MSB   = 31;
  localparam int unsigned SUBCODE_LSB = 32;
  localparam int unsigned SUBCODE_MSB = 39;
  localparam int unsigned INFO_LSB    = 40;
  localparam int unsigned INFO_MSB    = 55;
  localparam int unsigned DSTID_LSB   = 56;
  localparam int unsigned DSTID_MSB   = 58;
  localparam int unsigned DP_BIT      = 62;
  localparam int unsigned CP_BIT      = 63;

  typedef enum logic [4:0] {
    OPC_MEM_RD32         = 5'b00000,
    OPC_MEM_WR32         = 5'b00001,
    Message_without_Data = 5'b10010,
    Message_with_Data    = 5'b11011
  } opcode_t;

  typedef enum logic [2:0] {
    SRC_RSVD = 3'd0,
    SRC_D2D  = 3'd1,
    SRC_PHY  = 3'd2,
    SRC_MGMT = 3'd3
  } srcid_t;

  typedef enum logic [2:0] {
    DST_RSVD = 3'd0,
    DST_D2D  = 3'd1,
    DST_PHY  = 3'd2,
    DST_MGMT = 3'd3
  } dstid_t;

  typedef enum logic [3:0] {
    SB_msg_unknown           = 4'd0,
    SBINIT_out_of_reset      = 4'd1,
    SBINIT_done_req          = 4'd2,
    SBINIT_done_resp         = 4'd3,
    MBINIT_PARAM_config_req  = 4'd4,
    MBINIT_PARAM_config_resp = 4'd5,
    MBINIT_CAL_done_req      = 4'd6,
    MBINIT_CAL_done_resp     = 4'd7
  } msg_num_t;

  typedef struct packed {
    msg_num_t    msg_num;
    opcode_t     opcode;
    srcid_t      srcid;
    dstid_t      dstid;
    logic [15:0] msg_info;
  } SB_msg_t;

  function automatic SB_msg_t reset_SB_msg();
    SB_msg_t m;
    m.msg_num  = SB_msg_unknown;
    m.opcode   = OPC_MEM_RD32;
    m.srcid    = SRC_RSVD;
    m.dstid    = DST_RSVD;
    m.msg_info = '0;
    return m;
  endfunction

  function automatic msg_num_t decode_msg_num(input logic [7:0] msgcode,
                                              input logic [7:0] msgsubcode);
    msg_num_t n;
    case ({msgcode, msgsubcode})
      16'h9100: n = SBINIT_out_of_reset;
      16'h9501: n = SBINIT_done_req;
      16'h9A01: n = SBINIT_done_resp;
      16'hA500: n = MBINIT_PARAM_config_req;
      16'hAA00: n = MBINIT_PARAM_config_resp;
      16'hA502: n = MBINIT_CAL_done_req;
      16'hAA02: n = MBINIT_CAL_done_resp;
      default:  n = SB_msg_unknown;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and extra-MSB pointers.
module sb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sb_rx_msg_responder.sv
// Sideband RX responder: parity check, decode, buffering and one-message-per-
// request delivery to the active LTSM state.
module sb_rx_msg_responder
  import SB_codex_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             pkt_valid_i,
  input  logic [63:0]      pkt_header_i,
  input  logic [63:0]      pkt_data_i,
  input  logic             SB_RX_msg_req_i,
  output SB_msg_t          SB_RX_msg_o,
  output logic [63:0]      SB_RX_dataBus_o,
  output logic             SB_RX_msg_valid_o,
  output logic             fifo_empty_o,
  output logic             fifo_full_o,
  output logic [CNT_W-1:0] parity_err_cnt_o,
  output logic [CNT_W-1:0] overflow_cnt_o
);
  localparam int unsigned ENTRY_W = $bits(SB_msg_t) + 64;

  SB_msg_t            pkt_msg, head_msg, msg_q, msg_d;
  logic [63:0]        head_data, data_q, data_d;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               valid_q, valid_d, pend_q, pend_d;
  logic [CNT_W-1:0]   perr_q, perr_d, ovf_q, ovf_d;
  logic               clear, pkt_live, cp_ok, dp_ok, push, deliver, overflow, parity_bad;

  always_comb begin
    pkt_msg          = reset_SB_msg();
    pkt_msg.msg_num  = decode_msg_num(pkt_header_i[MSGCODE_MSB:MSGCODE_LSB],
                                      pkt_header_i[SUBCODE_MSB:SUBCODE_LSB]);
    pkt_msg.opcode   = opcode_t'(pkt_header_i[OPC_MSB:OPC_LSB]);
    pkt_msg.srcid    = srcid_t'(pkt_header_i[SRCID_MSB:SRCID_LSB]);
    pkt_msg.dstid    = dstid_t'(pkt_header_i[DSTID_MSB:DSTID_LSB]);
    pkt_msg.msg_info = pkt_header_i[INFO_MSB:INFO_LSB];
  end

  assign cp_ok = (pkt_header_i[CP_BIT] == ^pkt_header_i[DP_BIT-1:0]);
  assign dp_ok = (pkt_msg.opcode != Message_with_Data) ||
                 (pkt_header_i[DP_BIT] == ^pkt_data_i);

  // Packets arriving during a flush or while disabled vanish without being counted.
  assign clear      = flush_i || !enable_i;
  assign pkt_live   = pkt_valid_i && !clear;
  assign parity_bad = pkt_live && !(cp_ok && dp_ok);
  assign push       = pkt_live && cp_ok && dp_ok;
  assign deliver    = (pend_q || SB_RX_msg_req_i) && !fifo_empty_o && !clear && !valid_q;
  assign overflow   = push && fifo_full_o && !deliver;

  assign {head_msg, head_data} = fifo_dout;

  sb_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (deliver),
    .flush_i   (clear),
    .din_i     ({pkt_msg, pkt_data_i}),
    .dout_o    (fifo_dout),
    .empty_o   (fifo_empty_o),
    .full_o    (fifo_full_o)
  );

  always_comb begin
    valid_d = deliver;
    msg_d   = msg_q;
    data_d  = data_q;
    pend_d  = pend_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    if (deliver) begin
      msg_d  = head_msg;
      data_d = head_data;
    end
    if (clear || deliver) pend_d = 1'b0;
    else if (SB_RX_msg_req_i) pend_d = 1'b1;
    if (parity_bad && (perr_q != '1)) perr_d = perr_q + 1'b1;
    if (overflow && (ovf_q != '1))    ovf_d  = ovf_q + 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      valid_q <= 1'b0;
      msg_q   <= reset_SB_msg();
      data_q  <= '0;
      pend_q  <= 1'b0;
      perr_q  <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign SB_RX_msg_valid_o = valid_q;
  assign SB_RX_msg_o       = msg_q;
  assign SB_RX_dataBus_o   = data_q;
  assign parity_err_cnt_o  = perr_q;
  assign overflow_cnt_o    = ovf_q;

endmodule

// File: tb/tb_sb_rx_msg_responder.sv
// Bench for sb_rx_msg_responder: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_sb_rx_msg_responder;
  import SB_codex_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk_100MHz = 1'b0;
  logic             reset, enable_i, flush_i, pkt_valid_i, req_i;
  logic [63:0]      hdr_i, data_i;
  SB_msg_t          msg_o;
  logic [63:0]      bus_o;
  logic             valid_o, empty_o, full_o;
  logic [CNT_W-1:0] perr_o, ovf_o;

  always #5 clk_100MHz = ~clk_100MHz;

  sb_rx_msg_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_100MHz       (clk_100MHz),
    .reset            (reset),
    .enable_i         (enable_i),
    .flush_i          (flush_i),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_header_i     (hdr_i),
    .pkt_data_i       (data_i),
    .SB_RX_msg_req_i  (req_i),
    .SB_RX_msg_o      (msg_o),
    .SB_RX_dataBus_o  (bus_o),
    .SB_RX_msg_valid_o(valid_o),
    .fifo_empty_o     (empty_o),
    .fifo_full_o      (full_o),
    .parity_err_cnt_o (perr_o),
    .overflow_cnt_o   (ovf_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Known message codes as a lookup table.
  typedef struct {logic [7:0] c; logic [7:0] s; msg_num_t n;} code_t;
  code_t codes[7];

  function automatic msg_num_t ref_num(input logic [7:0] c, input logic [7:0] s);
    foreach (codes[i]) if (codes[i].c == c && codes[i].s == s) return codes[i].n;
    return SB_msg_unknown;
  endfunction

  function automatic logic [127:0] mk(input logic [4:0] opc, input logic [7:0] mc,
                                      input logic [7:0] sc, input logic [2:0] src,
                                      input logic [2:0] dst, input logic [15:0] info,
                                      input logic [63:0] d, input bit bad_cp, input bit bad_dp);
    logic [63:0] h;
    h          = '0;
    h[4:0]     = opc;
    h[13:5]    = 9'($urandom);
    h[21:14]   = mc;
    h[28:22]   = 7'($urandom);
    h[31:29]   = src;
    h[39:32]   = sc;
    h[55:40]   = info;
    h[58:56]   = dst;
    h[61:59]   = 3'($urandom);
    h[62]      = (^d) ^ bad_dp;
    h[63]      = (^h[61:0]) ^ bad_cp;
    return {h, d};
  endfunction

  // Reference model: a queue of accepted packets plus request/valid bookkeeping.
  typedef struct {logic [63:0] h; logic [63:0] d;} ent_t;
  ent_t        mq[$];
  bit          m_pend, m_vprev;
  int          m_perr, m_ovf;
  SB_msg_t     m_msg;
  logic [63:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_vprev = 0; m_perr = 0; m_ovf = 0;
    m_msg = '0; m_data = '0;
  endtask

  task automatic model_step(input bit en, input bit fl, input bit pv,
                            input logic [63:0] h, input logic [63:0] d, input bit rq);
    bit   deliver, accept, cp_ok, dp_ok;
    ent_t e;
    deliver = 0; accept = 0;
    if (fl || !en) begin
      mq.delete();
      m_pend = 0;
    end else begin
      deliver = (m_pend || rq) && (mq.size() > 0) && !m_vprev;
      if (pv) begin
        cp_ok = (h[63] == ^h[61:0]);
        dp_ok = (h[4:0] != 5'b11011) || (h[62] == ^d);
        if (!(cp_ok && dp_ok)) begin
          if (m_perr < 255) m_perr++;
        end else if (mq.size() == DEPTH && !deliver) begin
          if (m_ovf < 255) m_ovf++;
        end else accept = 1;
      end
      if (deliver) begin
        e      = mq.pop_front();
        m_msg  = SB_msg_t'({ref_num(e.h[21:14], e.h[39:32]), e.h[4:0], e.h[31:29],
                            e.h[58:56], e.h[55:40]});
        m_data = e.d;
      end
      if (accept) mq.push_back('{h, d});
      if (deliver) m_pend = 0;
      else if (rq) m_pend = 1;
    end
    m_vprev = deliver;
  endtask

  task automatic check_all();
    chk("valid",    valid_o, m_vprev);
    chk("empty",    empty_o, mq.size() == 0);
    chk("full",     full_o,  mq.size() == DEPTH);
    chk("perr_cnt", perr_o,  m_perr);
    chk("ovf_cnt",  ovf_o,   m_ovf);
    chk("msg",      msg_o,   m_msg);
    chk("data",     bus_o,   m_data);
  endtask

  task automatic cycle(input bit en, input bit fl, input bit pv,
                       input logic [63:0] h, input logic [63:0] d, input bit rq);
    enable_i = en; flush_i = fl; pkt_valid_i = pv; hdr_i = h; data_i = d; req_i = rq;
    @(posedge clk_100MHz);
    model_step(en, fl, pv, h, d, rq);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle();                 cycle(1, 0, 0, '0, '0, 0); endtask
  task automatic reqc();                 cycle(1, 0, 0, '0, '0, 1); endtask
  task automatic flushc();               cycle(1, 1, 0, '0, '0, 0); endtask
  task automatic pkt(input logic [127:0] p); cycle(1, 0, 1, p[127:64], p[63:0], 0); endtask

  task automatic do_reset();
    reset = 1; enable_i = 1; flush_i = 0; pkt_valid_i = 0; hdr_i = '0; data_i = '0; req_i = 0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset = 0;
    model_reset();
    cyc = 0;
    check_all();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
  endtask

  typedef struct {
    logic [4:0] opc; logic [7:0] mc; logic [7:0] sc;
    bit bad_cp; bit bad_dp; msg_num_t exp_num; bit exp_drop;
  } vec_t;
  vec_t vt[9];

  logic [127:0] p;

  initial begin
    codes[0] = '{8'h91, 8'h00, SBINIT_out_of_reset};
    codes[1] = '{8'h95, 8'h01, SBINIT_done_req};
    codes[2] = '{8'h9A, 8'h01, SBINIT_done_resp};
    codes[3] = '{8'hA5, 8'h00, MBINIT_PARAM_config_req};
    codes[4] = '{8'hAA, 8'h00, MBINIT_PARAM_config_resp};
    codes[5] = '{8'hA5, 8'h02, MBINIT_CAL_done_req};
    codes[6] = '{8'hAA, 8'h02, MBINIT_CAL_done_resp};

    vt[0] = '{5'b10010, 8'h91, 8'h00, 0, 0, SBINIT_out_of_reset,      0};
    vt[1] = '{5'b10010, 8'h95, 8'h01, 0, 0, SBINIT_done_req,          0};
    vt[2] = '{5'b10010, 8'h9A, 8'h01, 0, 0, SBINIT_done_resp,         0};
    vt[3] = '{5'b11011, 8'hA5, 8'h00, 0, 0, MBINIT_PARAM_config_req,  0};
    vt[4] = '{5'b11011, 8'hAA, 8'h00, 0, 0, MBINIT_PARAM_config_resp, 0};
    vt[5] = '{5'b10010, 8'h55, 8'h07, 0, 0, SB_msg_unknown,           0};
    vt[6] = '{5'b10010, 8'h91, 8'h00, 1, 0, SB_msg_unknown,           1};
    vt[7] = '{5'b11011, 8'hA5, 8'h02, 0, 1, SB_msg_unknown,           1};
    vt[8] = '{5'b10010, 8'hA5, 8'h02, 0, 1, MBINIT_CAL_done_req,      0};

    do_reset();

    foreach (vt[i]) begin
      pkt(mk(vt[i].opc, vt[i].mc, vt[i].sc, 3'd2, 3'd1, 16'(i), 64'($urandom),
             vt[i].bad_cp, vt[i].bad_dp));
      reqc();
      chk("vec_valid", valid_o, !vt[i].exp_drop);
      if (!vt[i].exp_drop) chk("vec_num", msg_o.msg_num, vt[i].exp_num);
      idle();
      chk("vec_valid_low", valid_o, 1'b0);
      flushc();
    end

    // Single message, delayed request.
    do_reset();
    pkt(mk(5'b10010, 8'h91, 8'h00, 3'd2, 3'd3, 16'h1234, 64'h0, 0, 0));
    while (cyc < 9) idle();
    reqc();
    chk("tp1_valid", valid_o, 1'b1);
    chk("tp1_num",   msg_o.msg_num, SBINIT_out_of_reset);
    chk("tp1_srcid", msg_o.srcid, 3'd2);
    chk("tp1_dstid", msg_o.dstid, 3'd3);
    idle();
    chk("tp1_valid_low", valid_o, 1'b0);
    chk("tp1_empty", empty_o, 1'b1);

    // Request while empty, packet later.
    do_reset();
    reqc();
    repeat (4) idle();
    pkt(mk(5'b10010, 8'h95, 8'h01, 3'd2, 3'd2, 16'h0, 64'h0, 0, 0));
    chk("tp2_push_cycle", valid_o, 1'b0);
    idle();
    chk("tp2_valid", valid_o, 1'b1);
    chk("tp2_num",   msg_o.msg_num, SBINIT_done_req);
    repeat (4) begin idle(); chk("tp2_no_second", valid_o, 1'b0); end

    // Parity drops.
    do_reset();
    pkt(mk(5'b10010, 8'h91, 8'h00, 3'd1, 3'd2, 16'h0, 64'h5, 1, 0));
    pkt(mk(5'b11011, 8'hA5, 8'h00, 3'd1, 3'd2, 16'h0, 64'h7, 0, 1));
    idle();
    chk("tp3_perr",  perr_o, 2);
    chk("tp3_empty", empty_o, 1'b1);

    // Overflow with in-order drain.
    do_reset();
    for (int i = 0; i < 6; i++) pkt(mk(5'b11011, 8'hA5, 8'h00, 3'd2, 3'd2, 16'(i), 64'(i * 7), 0, 0));
    chk("tp4_full", full_o, 1'b1);
    chk("tp4_ovf",  ovf_o, 2);
    for (int i = 0; i < 4; i++) begin
      reqc();
      chk("tp4_valid", valid_o, 1'b1);
      chk("tp4_order", msg_o.msg_info, 16'(i));
      chk("tp4_data",  bus_o, 64'(i * 7));
      idle();
    end
    chk("tp4_empty", empty_o, 1'b1);

    // Full, request and push in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) pkt(mk(5'b10010, 8'h91, 8'h00, 3'd2, 3'd2, 16'(i + 8), 64'h0, 0, 0));
    p = mk(5'b10010, 8'h9A, 8'h01, 3'd2, 3'd2, 16'hBEEF, 64'h0, 0, 0);
    cycle(1, 0, 1, p[127:64], p[63:0], 1);
    chk("tp5_valid", valid_o, 1'b1);
    chk("tp5_head",  msg_o.msg_info, 16'd8);
    chk("tp5_ovf",   ovf_o, 0);
    chk("tp5_full",  full_o, 1'b1);

    // Flush, dead request, disabled packet, then counter saturation.
    do_reset();
    for (int i = 0; i < 3; i++) pkt(mk(5'b10010, 8'h91, 8'h00, 3'd2, 3'd2, 16'(i), 64'h0, 0, 0));
    flushc();
    chk("tp6_empty", empty_o, 1'b1);
    reqc();
    repeat (3) begin idle(); chk("tp6_no_valid", valid_o, 1'b0); end
    p = mk(5'b10010, 8'h91, 8'h00, 3'd2, 3'd2, 16'h0, 64'h0, 1, 0);
    cycle(0, 0, 1, p[127:64], p[63:0], 0);
    chk("tp6_dis_perr", perr_o, 0);
    flushc();
    for (int i = 0; i < DEPTH + 260; i++) pkt(mk(5'b10010, 8'h91, 8'h00, 3'd2, 3'd2, 16'(i), 64'h0, 0, 0));
    chk("tp6_ovf_sat", ovf_o, 255);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int unsigned k, o;
      logic [4:0] opc;
      logic [7:0] mc, sc;
      k = $urandom_range(0, 7);
      if (k < 7) begin mc = codes[k].c; sc = codes[k].s; end
      else begin mc = 8'($urandom); sc = 8'($urandom); end
      o = $urandom_range(0, 3);
      opc = (o == 0) ? 5'b10010 : (o == 1) ? 5'b11011 : (o == 2) ? 5'b00000 : 5'b00001;
      p = mk(opc, mc, sc, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 16'($urandom),
             {32'($urandom), 32'($urandom)}, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      cycle($urandom_range(0, 39) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 5,
            p[127:64], p[63:0], $urandom_range(0, 9) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
